// File: rtl/banked_ram_ctrl_if.sv
// banked_ram_ctrl_if: access bus and status lines of banked_ram_ctrl.
// With PARITY_EN defined the bus also carries par_inject and par_err.
interface banked_ram_ctrl_if #(
    parameter int DATA_W = 4,
    parameter int ROW_W  = 2,
    parameter int COL_W  = 2,
    parameter int BANK_W = 2
);
    logic              cs, we, oe, clr;
    logic [BANK_W-1:0] bank_sel;
    logic [ROW_W-1:0]  addr_row;
    logic [COL_W-1:0]  addr_col;
    logic [DATA_W-1:0] datain, dataout;
    logic              rd_valid, busy, err;
`ifdef PARITY_EN
    logic              par_inject, par_err;
    modport master (output cs, we, oe, clr, bank_sel, addr_row, addr_col, datain, par_inject,
                    input dataout, rd_valid, busy, err, par_err);
    modport slave  (input cs, we, oe, clr, bank_sel, addr_row, addr_col, datain, par_inject,
                    output dataout, rd_valid, busy, err, par_err);
`else
    modport master (output cs, we, oe, clr, bank_sel, addr_row, addr_col, datain,
                    input dataout, rd_valid, busy, err);
    modport slave  (input cs, we, oe, clr, bank_sel, addr_row, addr_col, datain,
                    output dataout, rd_valid, busy, err);
`endif
endinterface

// File: rtl/banked_ram_ctrl.sv
// banked_ram_ctrl: multi-bank RAM with registered read, hardware clear sweep and bank range check.
// Define PARITY_EN to store an even-parity bit per word and flag mismatches on read.
module banked_ram_ctrl #(
    parameter int DATA_W    = 4,
    parameter int ROW_W     = 2,
    parameter int COL_W     = 2,
    parameter int NUM_BANKS = 2,
    parameter int BANK_W    = 2
) (
    input logic              clk,
    input logic              rst_n,
    banked_ram_ctrl_if.slave bus
);
    localparam int LOC_W = ROW_W + COL_W;
    localparam int IDX_W = NUM_BANKS > 1 ? $clog2(NUM_BANKS) : 1;
    localparam logic [BANK_W:0] NB = (BANK_W+1)'(NUM_BANKS);
`ifdef PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif
    typedef enum logic {CLEAR, IDLE} state_t;
    state_t           state;
    logic [LOC_W-1:0] cnt, loc;
    logic [IDX_W-1:0] idx;
    logic [MEM_W-1:0] mem [NUM_BANKS][2**LOC_W];
    logic [MEM_W-1:0] wdata, rword;
    logic             in_range, acc, wr, rd, oor;
    always_comb begin
        loc      = {bus.addr_row, bus.addr_col};
        idx      = bus.bank_sel[IDX_W-1:0];
        in_range = {1'b0, bus.bank_sel} < NB;
        acc      = state == IDLE && !bus.clr && bus.cs;
        wr       = acc && bus.we && in_range;
        rd       = acc && !bus.we && bus.oe && in_range;
        oor      = acc && (bus.we || bus.oe) && !in_range;
        rword    = mem[idx][loc];
`ifdef PARITY_EN
        wdata    = {^bus.datain ^ bus.par_inject, bus.datain};
`else
        wdata    = bus.datain;
`endif
    end
    // Storage has no reset; the sweep zeroes one location per cycle in every bank.
    always_ff @(posedge clk) begin
        if (state == CLEAR)
            for (int b = 0; b < NUM_BANKS; b++) mem[b][cnt] <= '0;
        if (wr) mem[idx][loc] <= wdata;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= CLEAR;
            cnt          <= '0;
            bus.busy     <= 1'b1;
            bus.dataout  <= '0;
            bus.rd_valid <= 1'b0;
            bus.err      <= 1'b0;
`ifdef PARITY_EN
            bus.par_err  <= 1'b0;
`endif
        end else begin
            bus.rd_valid <= rd;
            bus.err      <= oor;
`ifdef PARITY_EN
            bus.par_err  <= rd && ^rword;
`endif
            if (rd) bus.dataout <= rword[DATA_W-1:0];
            if (bus.clr) begin
                state    <= CLEAR;
                cnt      <= '0;
                bus.busy <= 1'b1;
            end else if (state == CLEAR) begin
                cnt <= cnt + 1'b1;
                if (&cnt) begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            end
        end
    end
endmodule
